pipeline_ctrl: RTL and testbench

//  Central hazard/redirect controller for the 5-stage pipeline. Merges stall requests from
//  IF/ID/EX/MEM with branch and trap redirects and drives the per-register flush_valid/stall_valid

---
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller for the 5-stage pipeline: merges stall requests with branch/trap
// redirects into per-register flush/stall buses, defers redirects behind in-flight MEM accesses.
module pipeline_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall_req_i,
  input  logic            load_use_req_i,
  input  logic            ex_stall_req_i,
  input  logic            mem_stall_req_i,
  input  logic            branch_redirect_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            trap_redirect_i,
  input  logic [XLEN-1:0] trap_pc_i,
  output logic [5:0]      flush_valid_o,
  output logic [5:0]      stall_valid_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [63:0]     stall_cycles_o,
  output logic            timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {RUN, WAIT_MEM} state_t;

  state_t          state;
  logic            pend_trap;
  logic [XLEN-1:0] pend_pc;
  logic [63:0]     stall_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  logic [5:0]      haz_flush, haz_stall;
  logic            branch_live, redirect_live;
  logic            issue, issue_trap, capture;
  logic [XLEN-1:0] issue_pc;

  // Stall masks nest, so the highest stalling request alone sets both stall and bubble bits.
  function automatic logic [11:0] hazard_masks(input logic ifs, input logic lu,
                                               input logic ex, input logic mem);
    logic [5:0] s, f;
    s = '0;
    f = '0;
    if (mem) begin
      s = 6'b001111; f = 6'b010000;
    end else if (ex) begin
      s = 6'b000111; f = 6'b001000;
    end else if (lu) begin
      s = 6'b000011; f = 6'b000100;
    end else if (ifs) begin
      s = 6'b000001; f = 6'b000010;
    end
    return {f, s};
  endfunction

  function automatic logic [5:0] redirect_flush(input logic is_trap);
    return is_trap ? 6'b011110 : 6'b000110;
  endfunction

  always_comb begin
    {haz_flush, haz_stall} = hazard_masks(if_stall_req_i, load_use_req_i,
                                          ex_stall_req_i, mem_stall_req_i);
    branch_live   = branch_redirect_i && !ex_stall_req_i;
    redirect_live = trap_redirect_i || branch_live;
    issue         = 1'b0;
    issue_trap    = 1'b0;
    issue_pc      = '0;
    capture       = 1'b0;

    if (state == RUN) begin
      if (redirect_live && !mem_stall_req_i) begin
        issue      = 1'b1;
        issue_trap = trap_redirect_i;
        issue_pc   = trap_redirect_i ? trap_pc_i : branch_pc_i;
      end else if (redirect_live) begin
        capture = 1'b1;
      end
    end else if (!mem_stall_req_i) begin
      issue      = 1'b1;
      issue_trap = pend_trap;
      issue_pc   = pend_pc;
    end

    flush_valid_o    = haz_flush | (issue ? redirect_flush(issue_trap) : 6'b000000);
    stall_valid_o    = haz_stall & ~flush_valid_o;
    if (issue) stall_valid_o[0] = 1'b0;
    redirect_valid_o = issue;
    redirect_pc_o    = issue_pc;

    if (rst) begin
      flush_valid_o    = '0;
      stall_valid_o    = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pend_trap <= 1'b0;
      pend_pc   <= '0;
      stall_cnt <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (capture) begin
            state     <= WAIT_MEM;
            pend_trap <= trap_redirect_i;
            pend_pc   <= trap_redirect_i ? trap_pc_i : branch_pc_i;
          end
        end
        WAIT_MEM: begin
          if (!mem_stall_req_i) begin
            state     <= RUN;
            pend_trap <= 1'b0;
          end else if (trap_redirect_i && !pend_trap) begin
            pend_trap <= 1'b1;
            pend_pc   <= trap_pc_i;
          end
        end
        default: state <= RUN;
      endcase

      stall_cnt <= stall_cnt + 64'(stall_valid_o[0]);

      // Watchdog saturates at the limit; the flag is sticky until reset.
      if (stall_valid_o[0]) begin
        if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign stall_cycles_o = stall_cnt;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes model expectations, a negedge monitor
// pops and compares the DUT outputs every cycle.
module tb_pipeline_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_stall_req_i, load_use_req_i, ex_stall_req_i, mem_stall_req_i;
  logic            branch_redirect_i, trap_redirect_i;
  logic [XLEN-1:0] branch_pc_i, trap_pc_i;
  logic [5:0]      flush_valid_o, stall_valid_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic [63:0]     stall_cycles_o;
  logic            timeout_o;

  pipeline_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req_i(if_stall_req_i), .load_use_req_i(load_use_req_i),
    .ex_stall_req_i(ex_stall_req_i), .mem_stall_req_i(mem_stall_req_i),
    .branch_redirect_i(branch_redirect_i), .branch_pc_i(branch_pc_i),
    .trap_redirect_i(trap_redirect_i), .trap_pc_i(trap_pc_i),
    .flush_valid_o(flush_valid_o), .stall_valid_o(stall_valid_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .stall_cycles_o(stall_cycles_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      f;
    logic [5:0]      s;
    logic            rv;
    logic [XLEN-1:0] pc;
    logic            chk_pc;
    logic [63:0]     cnt;
    logic            to;
    int              id;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc_id = 0;

  // Reference model state, kept in terms of "what is pending" rather than FSM encoding.
  bit              m_pend;
  bit              m_pend_trap;
  logic [XLEN-1:0] m_pend_pc;
  logic [63:0]     m_cnt;
  int              m_wd;
  bit              m_to;

  task automatic check(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, id, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("flush_valid", e.id, 64'(flush_valid_o), 64'(e.f));
      check("stall_valid", e.id, 64'(stall_valid_o), 64'(e.s));
      check("redirect_valid", e.id, 64'(redirect_valid_o), 64'(e.rv));
      if (e.chk_pc) check("redirect_pc", e.id, 64'(redirect_pc_o), 64'(e.pc));
      check("stall_cycles", e.id, stall_cycles_o, e.cnt);
      check("timeout", e.id, 64'(timeout_o), 64'(e.to));
    end
  end

  task automatic step(input bit r, input bit ifs, input bit lu, input bit ex, input bit mem,
                      input bit br, input logic [XLEN-1:0] bpc,
                      input bit tr, input logic [XLEN-1:0] tpc);
    exp_t e;
    int   hi;
    int   last;
    bit   go, gtrap;
    logic [XLEN-1:0] gpc;
    @(posedge clk);
    #1;
    rst = r; if_stall_req_i = ifs; load_use_req_i = lu; ex_stall_req_i = ex;
    mem_stall_req_i = mem; branch_redirect_i = br; branch_pc_i = bpc;
    trap_redirect_i = tr; trap_pc_i = tpc;

    e.f = '0; e.s = '0; e.rv = 1'b0; e.pc = '0; e.chk_pc = 1'b0;
    e.cnt = m_cnt; e.to = m_to; e.id = cyc_id;
    cyc_id++;
    if (r) begin
      e.chk_pc = 1'b1;
      m_pend = 0; m_pend_trap = 0; m_pend_pc = '0; m_cnt = '0; m_wd = 0; m_to = 0;
    end else begin
      hi = -1;
      if (ifs) hi = 0;
      if (lu)  hi = 1;
      if (ex)  hi = 2;
      if (mem) hi = 3;
      for (int i = 0; i <= hi; i++) e.s[i] = 1'b1;
      if (hi >= 0) e.f[hi+1] = 1'b1;
      go = 0; gtrap = 0; gpc = '0;
      if (!m_pend) begin
        if (tr || (br && !ex)) begin
          if (mem) begin
            m_pend = 1; m_pend_trap = tr; m_pend_pc = tr ? tpc : bpc;
          end else begin
            go = 1; gtrap = tr; gpc = tr ? tpc : bpc;
          end
        end
      end else if (!mem) begin
        go = 1; gtrap = m_pend_trap; gpc = m_pend_pc; m_pend = 0;
      end else if (tr && !m_pend_trap) begin
        m_pend_trap = 1; m_pend_pc = tpc;
      end
      if (go) begin
        last = gtrap ? 4 : 2;
        for (int i = 1; i <= last; i++) e.f[i] = 1'b1;
        e.s = e.s & ~e.f;
        e.s[0] = 1'b0;
        e.rv = 1'b1; e.pc = gpc; e.chk_pc = 1'b1;
      end
      if (e.s[0]) begin
        m_cnt = m_cnt + 64'd1;
        m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
        if (m_wd == TO) m_to = 1;
      end else begin
        m_wd = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    bit ifs, lu, ex, mem, br, tr, r;
    rst = 1'b1; if_stall_req_i = 0; load_use_req_i = 0; ex_stall_req_i = 0;
    mem_stall_req_i = 0; branch_redirect_i = 0; trap_redirect_i = 0;
    branch_pc_i = '0; trap_pc_i = '0;
    m_pend = 0; m_pend_trap = 0; m_pend_pc = '0; m_cnt = '0; m_wd = 0; m_to = 0;
    repeat (2) @(posedge clk);

    step(1, 1, 1, 0, 1, 1, 32'h1234, 1, 32'h5678);       // outputs forced low in reset
    idle(2);
    step(0, 0, 1, 0, 0, 0, '0, 0, '0);                   // load-use
    idle(1);
    step(0, 1, 0, 1, 0, 1, 32'h8000_0200, 0, '0);        // ex+if stall, branch ignored
    step(0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, '0);        // immediate branch
    step(0, 0, 0, 0, 0, 1, 32'h8000_0300, 1, 32'h8000_0008); // trap beats branch
    idle(1);
    step(0, 0, 0, 0, 1, 1, 32'h8000_0100, 0, '0);        // deferred branch
    step(0, 0, 0, 0, 1, 0, '0, 1, 32'h8000_0004);        // trap overwrites it
    step(0, 0, 0, 0, 1, 0, '0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 32'h8000_0400, 0, '0);        // pending trap issues, live branch dropped
    idle(2);
    step(1, 0, 0, 0, 0, 0, '0, 0, '0);
    for (int i = 0; i < TO; i++) step(0, 1, 0, 0, 0, 0, '0, 0, '0); // watchdog
    idle(3);
    step(1, 0, 0, 0, 0, 0, '0, 0, '0);
    idle(1);
    step(0, 0, 0, 0, 1, 0, '0, 1, 32'h8000_0004);        // pending trap, then reset
    step(1, 0, 0, 0, 1, 0, '0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0, 0, '0);
    idle(2);

    for (int n = 0; n < 1500; n++) begin
      ifs = ($urandom_range(99) < 15);
      lu  = ($urandom_range(99) < 15);
      ex  = ($urandom_range(99) < 15);
      mem = ($urandom_range(99) < 25);
      br  = ($urandom_range(99) < 20);
      tr  = ($urandom_range(99) < 8);
      r   = ($urandom_range(199) == 0);
      if (m_pend && mem && !m_pend_trap) br = 0;
      if (m_pend && mem && m_pend_trap) tr = 0;
      step(r, ifs, lu, ex, mem, br, $urandom(), tr, $urandom());
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
